// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM state encoding,
// a ceil-log2 helper and the widest round-robin pointer the arbiter supports.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'b00,
    ISSUE   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam int MAX_REQ = 16;

  // Never returns less than 1 so a 1-bit pointer still exists for tiny counts.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    if (bits == 0) begin
      bits = 1;
    end
    return bits;
  endfunction

  localparam int PTR_W_MAX = clog2(MAX_REQ);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit searching upward
// from ptr+1 with wrap-around, returned one-hot along with an any-request flag.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    // Offset NUM_REQ lands back on ptr itself, so the last winner is checked last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ requesters.
// Optional watchdog abort in ISSUE is enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH_A   = 8,
  parameter int DATA_WIDTH_B   = 8,
  parameter int DATA_WIDTH_C   = DATA_WIDTH_A + DATA_WIDTH_B,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*DATA_WIDTH_A-1:0] i_a,
  input  logic [NUM_REQ*DATA_WIDTH_B-1:0] i_b,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [NUM_REQ-1:0]              o_done,
  output logic [DATA_WIDTH_C-1:0]         o_c,
  output logic                            o_busy,
  output logic                            o_timeout,
  output logic [DATA_WIDTH_A-1:0]         o_mul_a,
  output logic [DATA_WIDTH_B-1:0]         o_mul_b,
  output logic                            o_mul_valid,
  input  logic [DATA_WIDTH_C-1:0]         i_mul_c,
  input  logic                            i_mul_accept
);

  localparam int PTR_W = clog2(NUM_REQ);

  logic [DATA_WIDTH_A-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH_B-1:0] b_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = i_a[gi*DATA_WIDTH_A +: DATA_WIDTH_A];
      assign b_arr[gi] = i_b[gi*DATA_WIDTH_B +: DATA_WIDTH_B];
    end
  endgenerate

  state_t                  state_reg,   state_next;
  logic [PTR_W-1:0]        ptr_reg,     ptr_next;
  logic [DATA_WIDTH_A-1:0] mul_a_reg,   mul_a_next;
  logic [DATA_WIDTH_B-1:0] mul_b_reg,   mul_b_next;
  logic                    valid_reg,   valid_next;
  logic [NUM_REQ-1:0]      grant_reg,   grant_next;
  logic [NUM_REQ-1:0]      done_reg,    done_next;
  logic [DATA_WIDTH_C-1:0] c_reg,       c_next;
  logic                    busy_reg,    busy_next;

  logic [NUM_REQ-1:0]      pick_grant;
  logic                    pick_any;
  logic [PTR_W-1:0]        pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .any   (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic             timeout_reg, timeout_next;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    mul_a_next = mul_a_reg;
    mul_b_next = mul_b_reg;
    valid_next = valid_reg;
    grant_next = '0;
    done_next  = '0;
    c_next     = c_reg;
    busy_next  = busy_reg;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      ARB: begin
        if (pick_any) begin
          mul_a_next = a_arr[pick_idx];
          mul_b_next = b_arr[pick_idx];
          valid_next = 1'b1;
          grant_next = pick_grant;
          ptr_next   = pick_idx;
          busy_next  = 1'b1;
          state_next = ISSUE;
`ifdef MUL_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      ISSUE: begin
        // The winner's index is the pointer, so done decodes straight from it.
        if (i_mul_accept) begin
          c_next     = i_mul_c;
          done_next  = NUM_REQ'(1) << ptr_reg;
          valid_next = 1'b0;
          state_next = RELEASE;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          c_next       = '0;
          done_next    = NUM_REQ'(1) << ptr_reg;
          timeout_next = 1'b1;
          valid_next   = 1'b0;
          state_next   = RELEASE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        if (!i_mul_accept) begin
          busy_next  = 1'b0;
          state_next = ARB;
        end
      end
      default: begin
        state_next = ARB;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_reg <= ARB;
      ptr_reg   <= PTR_W'(NUM_REQ - 1);
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      valid_reg <= 1'b0;
      grant_reg <= '0;
      done_reg  <= '0;
      c_reg     <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      mul_a_reg <= mul_a_next;
      mul_b_reg <= mul_b_next;
      valid_reg <= valid_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      c_reg     <= c_next;
      busy_reg  <= busy_next;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_timeout = timeout_reg;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_grant     = grant_reg;
  assign o_done      = done_reg;
  assign o_c         = c_reg;
  assign o_busy      = busy_reg;
  assign o_mul_a     = mul_a_reg;
  assign o_mul_b     = mul_b_reg;
  assign o_mul_valid = valid_reg;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a behavioural multiplier stub and a
// scoreboard of expected grant/product pairs; covers MUL_ARB_TIMEOUT_EN when defined.
module tb_mul_arbiter;

  logic        i_clk;
  logic        i_nrst;
  logic [3:0]  i_req;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [3:0]  o_grant;
  logic [3:0]  o_done;
  logic [15:0] o_c;
  logic        o_busy;
  logic        o_timeout;
  logic [7:0]  o_mul_a;
  logic [7:0]  o_mul_b;
  logic        o_mul_valid;
  logic [15:0] i_mul_c;
  logic        i_mul_accept;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Multiplier stub controls
  int mul_lat    = 3;
  bit stub_hold  = 1'b0;
  bit stub_dead  = 1'b0;
  int stub_st;
  int stub_cnt;

  logic [3:0]  exp_g_q [$];
  logic [15:0] exp_c_q [$];
  int          rnd [4];

  mul_arbiter dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_req        (i_req),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_grant      (o_grant),
    .o_done       (o_done),
    .o_c          (o_c),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_mul_a      (o_mul_a),
    .o_mul_b      (o_mul_b),
    .o_mul_valid  (o_mul_valid),
    .i_mul_c      (i_mul_c),
    .i_mul_accept (i_mul_accept)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // Stub: accept after mul_lat cycles of valid; pulse or hold-until-valid-low.
  always @(posedge i_clk) begin
    if (!i_nrst) begin
      stub_st      <= 0;
      stub_cnt     <= 0;
      i_mul_accept <= 1'b0;
      i_mul_c      <= '0;
    end else begin
      case (stub_st)
        0: if (o_mul_valid && !stub_dead) begin
          if (mul_lat <= 1) begin
            i_mul_accept <= 1'b1;
            i_mul_c      <= 16'(o_mul_a) * 16'(o_mul_b);
            stub_st      <= 2;
          end else begin
            stub_cnt <= 1;
            stub_st  <= 1;
          end
        end
        1: if (stub_cnt == mul_lat - 1) begin
          i_mul_accept <= 1'b1;
          i_mul_c      <= 16'(o_mul_a) * 16'(o_mul_b);
          stub_st      <= 2;
        end else begin
          stub_cnt <= stub_cnt + 1;
        end
        default: begin
          if (!stub_hold || !o_mul_valid) i_mul_accept <= 1'b0;
          if (!o_mul_valid) stub_st <= 0;
        end
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (i_nrst && (|o_grant || |o_done)) begin
      checks++;
      if (|o_grant && |o_done) begin
        failures++;
        $display("FAIL grant_done_overlap grant=%b done=%b required no overlap", o_grant, o_done);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i] === 1'b1) return i;
    return 0;
  endfunction

  function automatic logic [7:0] held_a(input int k, input int r);
    return 8'(16 * k + 3 * r + 1);
  endfunction

  function automatic logic [7:0] held_b(input int k, input int r);
    return 8'(255 - 7 * k - 5 * r);
  endfunction

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
    i_a[k*8 +: 8] = a;
    i_b[k*8 +: 8] = b;
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b);
    exp_g_q.push_back(g);
    exp_c_q.push_back(16'(a) * 16'(b));
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_nrst = 1'b0;
    i_req  = '0;
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  // Waits for each grant then its done, comparing against the scoreboard.
  task automatic serve(input int n, input bit hold);
    int cnt;
    int k;
    int last_g_cyc;
    logic [3:0]  g, eg, prev_g;
    logic [15:0] ec;
    last_g_cyc = -1;
    prev_g = '0;
    for (int j = 0; j < n; j++) begin
      cnt = 0;
      while (o_grant === 4'b0 && cnt < 300) begin
        @(negedge i_clk);
        cnt++;
      end
      checks++;
      if (o_grant === 4'b0 || exp_g_q.size() == 0) begin
        failures++;
        $display("FAIL grant_wait got=%b queued=%0d required a grant", o_grant, exp_g_q.size());
        return;
      end
      g  = o_grant;
      eg = exp_g_q.pop_front();
      ec = exp_c_q.pop_front();
      if (g !== eg) begin
        failures++;
        $display("FAIL grant_order got=%b required=%b", g, eg);
      end
      checks++;
      if (o_mul_valid !== 1'b1) begin
        failures++;
        $display("FAIL mul_valid_at_grant got=%b required=1", o_mul_valid);
      end
      if (hold) begin
        checks++;
        if (g === prev_g) begin
          failures++;
          $display("FAIL repeat_grant got=%b required different from previous", g);
        end
        if (last_g_cyc >= 0) begin
          checks++;
          if (cyc - last_g_cyc != mul_lat + 3) begin
            failures++;
            $display("FAIL throughput got=%0d required=%0d", cyc - last_g_cyc, mul_lat + 3);
          end
        end
      end
      prev_g = g;
      last_g_cyc = cyc;
      k = onehot_idx(g);
      if (hold) begin
        rnd[k]++;
        set_op(k, held_a(k, rnd[k]), held_b(k, rnd[k]));
        if (exp_g_q.size() == 0) i_req = '0;
      end else begin
        set_op(k, 8'hA5, 8'h5A);
        i_req[k] = 1'b0;
      end
      cnt = 0;
      do begin
        @(negedge i_clk);
        cnt++;
      end while (o_done === 4'b0 && cnt < 300);
      checks++;
      if (o_done === 4'b0) begin
        failures++;
        $display("FAIL done_wait got=%b required=%b", o_done, eg);
        return;
      end
      if (o_done !== eg) begin
        failures++;
        $display("FAIL done_vector got=%b required=%b", o_done, eg);
      end
      checks++;
      if (o_c !== ec) begin
        failures++;
        $display("FAIL product got=%0d required=%0d", o_c, ec);
      end
      checks++;
      if (cnt != mul_lat + 1) begin
        failures++;
        $display("FAIL latency got=%0d required=%0d", cnt, mul_lat + 1);
      end
      checks++;
      if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL done_flags timeout=%b busy=%b required timeout=0 busy=1", o_timeout, o_busy);
      end
      $display("txn grant=%b done=%b c=%0d expected=%0d", g, o_done, o_c, ec);
    end
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while (o_busy !== 1'b0 && cnt < 20) begin
      @(negedge i_clk);
      cnt++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy=%b required=0", name, o_busy);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({o_grant, o_done, o_c, o_busy, o_timeout, o_mul_a, o_mul_b, o_mul_valid} !== 43'b0) begin
      failures++;
      $display("FAIL %s grant=%b done=%b c=%0d busy=%b to=%b a=%0d b=%0d valid=%b required all 0",
               name, o_grant, o_done, o_c, o_busy, o_timeout, o_mul_a, o_mul_b, o_mul_valid);
    end
  endtask

  task automatic test_reset();
    i_nrst = 1'b0;
    i_req  = '0;
    i_a    = '0;
    i_b    = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_zero_outputs("reset_state");
    i_nrst = 1'b1;
    $display("txn reset outputs checked");
  endtask

  task automatic test_single();
    do_reset();
    stub_hold = 1'b1;
    set_op(0, 8'd3, 8'd5);
    i_req = 4'b0001;
    push_exp(4'b0001, 8'd3, 8'd5);
    serve(1, 1'b0);
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || o_mul_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_wait busy=%b valid=%b required busy=1 valid=0", o_busy, o_mul_valid);
    end
    wait_idle("single_idle");
    stub_hold = 1'b0;
  endtask

  task automatic test_pair();
    do_reset();
    set_op(0, 8'd2, 8'd7);
    set_op(1, 8'd4, 8'd9);
    i_req = 4'b0011;
    push_exp(4'b0001, 8'd2, 8'd7);
    push_exp(4'b0010, 8'd4, 8'd9);
    serve(2, 1'b0);
    wait_idle("pair_idle");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rnd[k] = 0;
      set_op(k, held_a(k, 0), held_b(k, 0));
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_exp(4'(1 << k), held_a(k, r), held_b(k, r));
      end
    end
    i_req = 4'b1111;
    serve(8, 1'b1);
    wait_idle("held_idle");
  endtask

  task automatic test_extremes();
    do_reset();
    set_op(0, 8'd0, 8'd200);
    set_op(1, 8'd255, 8'd255);
    i_req = 4'b0011;
    push_exp(4'b0001, 8'd0, 8'd200);
    push_exp(4'b0010, 8'd255, 8'd255);
    serve(2, 1'b0);
    wait_idle("extreme_idle");
  endtask

  task automatic test_reset_mid();
    int cnt;
    int dones;
    do_reset();
    set_op(2, 8'd9, 8'd9);
    i_req = 4'b0100;
    cnt = 0;
    while (o_grant === 4'b0 && cnt < 50) begin
      @(negedge i_clk);
      cnt++;
    end
    checks++;
    if (o_grant !== 4'b0100) begin
      failures++;
      $display("FAIL mid_grant got=%b required=0100", o_grant);
    end
    @(negedge i_clk);
    i_nrst = 1'b0;
    i_req  = '0;
    @(negedge i_clk);
    check_zero_outputs("reset_mid_issue");
    i_nrst = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_done !== 4'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abandoned_done got=%0d pulses required=0", dones);
    end
    set_op(0, 8'd6, 8'd7);
    set_op(3, 8'd11, 8'd13);
    i_req = 4'b1001;
    push_exp(4'b0001, 8'd6, 8'd7);
    push_exp(4'b1000, 8'd11, 8'd13);
    serve(2, 1'b0);
    wait_idle("post_reset_idle");
  endtask

`ifdef MUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    do_reset();
    stub_dead = 1'b1;
    set_op(1, 8'd5, 8'd5);
    i_req = 4'b0010;
    cnt = 0;
    while (o_grant === 4'b0 && cnt < 50) begin
      @(negedge i_clk);
      cnt++;
    end
    i_req = '0;
    cnt = 0;
    do begin
      @(negedge i_clk);
      cnt++;
    end while (o_done === 4'b0 && cnt < 300);
    checks++;
    if (cnt != 64) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d required=64", cnt);
    end
    checks++;
    if (o_timeout !== 1'b1 || o_done !== 4'b0010 || o_c !== 16'd0) begin
      failures++;
      $display("FAIL timeout_abort to=%b done=%b c=%0d required to=1 done=0010 c=0", o_timeout, o_done, o_c);
    end
    $display("txn timeout done=%b c=%0d after %0d cycles", o_done, o_c, cnt);
    wait_idle("timeout_idle");
    stub_dead = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_extremes();
    test_reset_mid();
`ifdef MUL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential shift-and-add multiplier between NUM_REQ requesters. It captures the winner's operands and drives the multiplier's valid/accept handshake. It returns the product to the winner with a one-hot done pulse. It sits between the requesting datapath blocks and a single sequential_multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH_A, 8, operand A width
DATA_WIDTH_B, 8, operand B width
DATA_WIDTH_C, DATA_WIDTH_A+DATA_WIDTH_B, product width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MUL_ARB_TIMEOUT_EN)

Ports:
i_clk  input  1  clock
i_nrst  input  1  reset; one clock; reset is synchronous and active-low
i_req  input  NUM_REQ  per-requester request level
i_a  input  NUM_REQ*DATA_WIDTH_A  packed operand A; requester k occupies slice k
i_b  input  NUM_REQ*DATA_WIDTH_B  packed operand B, same packing
o_grant  output  NUM_REQ  one-hot, 1-cycle pulse; operands of that requester captured
o_done  output  NUM_REQ  one-hot, 1-cycle pulse; o_c valid for that requester
o_c  output  DATA_WIDTH_C  registered product; holds until next done
o_busy  output  1  high while any operation is outstanding
o_timeout  output  1  1-cycle pulse on watchdog abort; tied 0 without macro
o_mul_a  output  DATA_WIDTH_A  to multiplier i_a
o_mul_b  output  DATA_WIDTH_B  to multiplier i_b
o_mul_valid  output  1  to multiplier i_valid
i_mul_c  input  DATA_WIDTH_C  from multiplier o_c
i_mul_accept  input  1  from multiplier o_accept

Behaviour:
Reset (i_nrst=0 at posedge): all outputs 0, state ARB, rr pointer = NUM_REQ-1 so requester 0 has top priority. The multiplier instance shares i_nrst. Reset mid-operation abandons the operation with no done pulse.
Requester rule: hold i_req high with operands stable until o_grant. After o_grant, the requester may drop i_req or change its operands. Keeping i_req high re-enters arbitration after the current done.
States:
ARB: if any i_req, pick the first set bit searching upward from pointer+1 with wrap. Register its operands into o_mul_a/o_mul_b. Set o_mul_valid=1, pulse o_grant[k], set pointer=k, o_busy=1, go ISSUE. If no i_req, stay in ARB.
ISSUE: hold o_mul_valid and operands. When i_mul_accept=1: o_c<=i_mul_c, pulse o_done[k], set o_mul_valid=0, go RELEASE.
RELEASE: keep o_mul_valid=0 until i_mul_accept=0. Then o_busy=0 and go ARB. The next grant comes no earlier than the cycle after ARB is entered.
Latency: grant to done equals multiplier latency plus 1 cycle. Back-to-back throughput is one operation per (multiplier latency + 3) cycles.
Zero operands: passed through unchanged; the multiplier handles them.
Requests arriving in ISSUE or RELEASE wait; there is no queueing beyond i_req levels.
A requester that drops i_req before grant is simply not selected; no error is raised.
o_grant and o_done are never asserted in the same cycle.

Optional Feature:
MUL_ARB_TIMEOUT_EN: defined adds a watchdog counter. The counter is cleared on entry to ISSUE and increments each ISSUE cycle. At TIMEOUT_CYCLES with no accept: pulse o_timeout, pulse o_done[k] with o_c=0, go RELEASE. Undefined: no counter, o_timeout tied 0, ISSUE waits indefinitely.

Decomposition:
Package mul_arb_pkg: state encoding (ARB=2'b00, ISSUE=2'b01, RELEASE=2'b10), clog2 function, pointer width constant. Sub-module rr_pick: combinational round-robin select. Its inputs are the request vector and pointer; its outputs are the one-hot grant and any-request flag. The FSM, operand mux and registers stay in mul_arbiter.

Test Plan:
Reset, then i_req=0001, A0=3, B0=5 -> o_grant=0001 pulse, o_mul_valid high until accept; o_done=0001 with o_c=15; o_busy drops after accept falls.
i_req=0011 same cycle, A0=2,B0=7, A1=4,B1=9 -> grant order 0 then 1; o_c=14 then 36.
i_req=1111 held for 8 operations -> grant sequence 0,1,2,3,0,1,2,3; no requester granted twice consecutively.
Operand extremes: A=0,B=200 -> o_c=0; A=255,B=255 -> o_c=65025.
i_nrst low for one cycle while in ISSUE -> all outputs 0 next cycle, no o_done; a new request after reset starts with requester 0 priority.
With MUL_ARB_TIMEOUT_EN and a stubbed multiplier that never accepts -> o_timeout pulse after 64 ISSUE cycles, o_done[k] with o_c=0, then ARB.
